de2_pio_led_blink: RTL and testbench

Parametrised Avalon-MM output PIO for board LED banks, the next generation of the single-register green-LED PIO. It adds atomic set/clear/toggle writes, a per-bit blink enable and a programmable blink timebase, so software can flash LEDs without polling. The block sits on the Nios II system interconnect as a zero-wait-state slave and drives `out_port` straight to the LED pins.

---
 rtl/de2_pio_led_blink_if.sv | 19 +
 rtl/de2_pio_led_blink.sv | 106 ++++++++++
 tb/tb_de2_pio_led_blink.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/de2_pio_led_blink_if.sv
// Avalon-MM slave bus bundle for the LED PIO: address, select, write strobe and data.
// The master drives the request side and the slave returns combinational read data.
interface de2_pio_led_blink_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/de2_pio_led_blink.sv
// LED output PIO with atomic set/clear/toggle writes and a per-bit hardware blink.
// The blink timebase is an up-counter over PERIOD cycles; each wrap inverts the phase.
module de2_pio_led_blink #(
    parameter int          WIDTH       = 9,
    parameter int          PERIOD_W    = 24,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    de2_pio_led_blink_if.slave    bus,
    output logic [WIDTH-1:0]      out_port
);
    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_BLINK  = 3'd1;
    localparam logic [2:0] A_PERIOD = 3'd2;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;
    localparam logic [2:0] A_OUTTGL = 3'd6;
    localparam logic [2:0] A_STATUS = 3'd7;

    logic [WIDTH-1:0]    data_q,   data_d;
    logic [WIDTH-1:0]    blink_q,  blink_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q,    cnt_d;
    logic                phase_q,  phase_d;
    logic [WIDTH-1:0]    out_q,    out_d;

    logic                wr;
    logic [WIDTH-1:0]    wd_bits;
    logic [PERIOD_W:0]   status_w;
    logic                unused_wd;

    assign wr        = bus.chipselect && !bus.write_n;
    assign wd_bits   = bus.writedata[WIDTH-1:0];
    assign status_w  = {cnt_q, phase_q};
    assign unused_wd = ^bus.writedata;

    always_comb begin
        data_d  = data_q;
        blink_d = blink_q;
        if (wr) begin
            unique case (bus.address)
                A_DATA:   data_d  = wd_bits;
                A_BLINK:  blink_d = wd_bits;
                A_OUTSET: data_d  = data_q | wd_bits;
                A_OUTCLR: data_d  = data_q & ~wd_bits;
                A_OUTTGL: data_d  = data_q ^ wd_bits;
                default:  ;
            endcase
        end
    end

    // A PERIOD write restarts the timebase and takes priority over terminal count.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (wr && bus.address == A_PERIOD) begin
            period_d = bus.writedata[PERIOD_W-1:0];
            cnt_d    = '0;
            phase_d  = 1'b1;
        end else if (period_q == '0) begin
            cnt_d    = '0;
            phase_d  = 1'b1;
        end else if (cnt_q == period_q - PERIOD_W'(1)) begin
            cnt_d    = '0;
            phase_d  = ~phase_q;
        end else begin
            cnt_d    = cnt_q + PERIOD_W'(1);
        end
    end

    assign out_d = data_q & (~blink_q | {WIDTH{phase_q}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= RESET_VALUE[WIDTH-1:0];
            blink_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            out_q    <= RESET_VALUE[WIDTH-1:0];
        end else begin
            data_q   <= data_d;
            blink_q  <= blink_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            out_q    <= out_d;
        end
    end

    assign out_port = out_q;

    // STATUS packs {counter, phase}; a 32-bit counter loses its top bit here.
    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            A_DATA:   bus.readdata = 32'(data_q);
            A_BLINK:  bus.readdata = 32'(blink_q);
            A_PERIOD: bus.readdata = 32'(period_q);
            A_STATUS: bus.readdata = 32'(status_w);
            default:  bus.readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_de2_pio_led_blink.sv
// Bench for de2_pio_led_blink: register-op table, blink corner sequences, async reset,
// then random traffic against a time-based reference model of the blink behaviour.
module tb_de2_pio_led_blink;
    localparam int          WIDTH    = 9;
    localparam int          PERIOD_W = 24;
    localparam logic [31:0] RV       = 32'h1A5;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] out_port;

    de2_pio_led_blink_if bus ();

    de2_pio_led_blink #(
        .WIDTH       (WIDTH),
        .PERIOD_W    (PERIOD_W),
        .RESET_VALUE (RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase and counter derived from edges elapsed since the last PERIOD write.
    logic [WIDTH-1:0]    m_data, m_blink, m_out;
    logic [PERIOD_W-1:0] m_period;
    longint              m_wedge;
    longint              n_edge;

    function automatic logic m_phase(input longint e);
        longint k;
        if (m_period == '0) return 1'b1;
        k = e - m_wedge;
        return ((k / longint'(m_period)) % 2) == 0;
    endfunction

    function automatic logic [PERIOD_W-1:0] m_cnt(input longint e);
        longint k;
        if (m_period == '0) return '0;
        k = e - m_wedge;
        return PERIOD_W'(k % longint'(m_period));
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd1:    return 32'(m_blink);
            3'd2:    return 32'(m_period);
            3'd7:    return 32'({m_cnt(n_edge), m_phase(n_edge)});
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_data   = RV[WIDTH-1:0];
        m_blink  = '0;
        m_period = '0;
        m_wedge  = 0;
        m_out    = RV[WIDTH-1:0];
        n_edge   = 0;
    endtask

    task automatic model_edge(input logic cs, input logic wn, input logic [2:0] a,
                              input logic [31:0] wd);
        logic [WIDTH-1:0] w9;
        m_out  = m_data & (~m_blink | {WIDTH{m_phase(n_edge)}});
        n_edge = n_edge + 1;
        w9 = wd[WIDTH-1:0];
        if (cs && !wn) begin
            case (a)
                3'd0: m_data  = w9;
                3'd1: m_blink = w9;
                3'd2: begin m_period = wd[PERIOD_W-1:0]; m_wedge = n_edge; end
                3'd4: m_data  = m_data | w9;
                3'd5: m_data  = m_data & ~w9;
                3'd6: m_data  = m_data ^ w9;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // One bus cycle, entered and left on a falling edge.
    task automatic step(input logic cs, input logic wn, input logic [2:0] a,
                        input logic [31:0] wd);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        #1;
        chk("readdata", bus.readdata, m_read(a));
        @(posedge clk);
        model_edge(cs, wn, a, wd);
        @(negedge clk);
        chk("out_port", 32'(out_port), 32'(m_out));
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, 1'b1, a, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        step(1'b1, 1'b0, a, wd);
    endtask

    typedef struct {
        logic        cs;
        logic        wn;
        logic [2:0]  a;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[21];

    logic [31:0] st_exp[5];
    logic [31:0] out_exp[5];
    logic [31:0] r, rwd;
    logic [2:0]  ra;
    int          guard;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 3'd0, 32'h0,         1'b1, 32'h1A5};
        vecs[1]  = '{1'b1, 1'b1, 3'd1, 32'h0,         1'b1, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 3'd2, 32'h0,         1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 3'd7, 32'h0,         1'b1, 32'h1};
        vecs[4]  = '{1'b1, 1'b1, 3'd3, 32'h0,         1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'd0, 32'hFFFF_F0F0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 3'd0, 32'h0,         1'b1, 32'h0F0};
        vecs[7]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0E03, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 3'd0, 32'h0,         1'b1, 32'h0F3};
        vecs[9]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0030, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'd6, 32'hABC0_0101, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 3'd0, 32'h0,         1'b1, 32'h1C2};
        vecs[12] = '{1'b1, 1'b1, 3'd4, 32'h0,         1'b1, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 3'd5, 32'h0,         1'b1, 32'h0};
        vecs[14] = '{1'b1, 1'b1, 3'd6, 32'h0,         1'b1, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'd3, 32'h0000_0001, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 1'b0, 3'd7, 32'h0000_FFFF, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 1'b1, 3'd7, 32'h0,         1'b1, 32'h1};
        vecs[19] = '{1'b1, 1'b1, 3'd0, 32'h0,         1'b1, 32'h1C2};
        vecs[20] = '{1'b1, 1'b1, 3'd3, 32'h0,         1'b1, 32'h0};

        st_exp  = '{32'h1, 32'h3, 32'h5, 32'h7, 32'h0};
        out_exp = '{32'h1FF, 32'h1FF, 32'h1FF, 32'h1FF, 32'h1F0};

        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_out", 32'(out_port), 32'h1A5);
        reset = 1'b0;

        // Register map and atomic set/clear/toggle.
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].cs, vecs[i].wn, vecs[i].a, vecs[i].wd);
            if (vecs[i].chk_rd) begin
                bus.address = vecs[i].a;
                #1;
                chk($sformatf("vec%0d_rd", i), bus.readdata, m_read(vecs[i].a));
            end
        end
        chk("atomic_out", 32'(out_port), 32'h1C2);

        // Blink with PERIOD=4: first toggle 4 edges after the write.
        wr(3'd0, 32'h1FF);
        wr(3'd1, 32'h00F);
        wr(3'd2, 32'h4);
        for (int i = 0; i < 5; i++) begin
            bus.address = 3'd7;
            #1;
            chk($sformatf("blink_status%0d", i), bus.readdata, st_exp[i]);
            rd(3'd7);
            chk($sformatf("blink_out%0d", i), 32'(out_port), out_exp[i]);
        end

        // Rewrite PERIOD=2 exactly on a terminal-count cycle.
        guard = 0;
        while (m_cnt(n_edge) != 24'd3 && guard < 10) begin
            rd(3'd7);
            guard++;
        end
        chk("tc_reached", 32'(guard < 10), 32'h1);
        wr(3'd2, 32'h2);
        for (int i = 0; i < 3; i++) begin
            bus.address = 3'd7;
            #1;
            chk($sformatf("tc_status%0d", i), bus.readdata,
                (i == 0) ? 32'h1 : (i == 1) ? 32'h3 : 32'h0);
            rd(3'd7);
        end

        // PERIOD=0 while phase is 0 forces steady DATA.
        guard = 0;
        while (m_phase(n_edge) != 1'b0 && guard < 10) begin
            rd(3'd7);
            guard++;
        end
        chk("phase0_reached", 32'(guard < 10), 32'h1);
        wr(3'd2, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.address = 3'd7;
            #1;
            chk($sformatf("stop_status%0d", i), bus.readdata, 32'h1);
            rd(3'd7);
            chk($sformatf("stop_out%0d", i), 32'(out_port), 32'h1FF);
        end

        // Asynchronous reset mid-count.
        wr(3'd0, 32'h0F0);
        wr(3'd2, 32'h3);
        rd(3'd7);
        rd(3'd7);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = 3'd2;
        #2 reset = 1'b1;
        #1;
        chk("async_out", 32'(out_port), 32'h1A5);
        chk("async_period", bus.readdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Reset during a write strobe: the write is lost.
        wr(3'd1, 32'h0FF);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 3'd0;
        bus.writedata  = 32'h055;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("wr_reset_out", 32'(out_port), 32'h1A5);
        @(negedge clk);
        bus.write_n = 1'b1;
        reset = 1'b0;
        model_reset();
        bus.address = 3'd0;
        #1;
        chk("wr_reset_data", bus.readdata, 32'h1A5);
        bus.address = 3'd1;
        #1;
        chk("wr_reset_blink", bus.readdata, 32'h0);
        #3;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r   = $urandom;
            ra  = r[2:0];
            rwd = $urandom;
            if (ra == 3'd2) rwd = {rwd[31:24], 24'($urandom_range(0, 5))};
            step(r[7:4] != 4'h0, r[9:8] != 2'b00, ra, rwd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
